// File: rtl/kong_key_input.sv
// Kong keyboard front-end: PS/2 events to held-key requests and a one-frame jump window.
// Optional feature: define KONG_JUMP_AUTOREPEAT_EN to re-arm jump while the key stays held.
module kong_key_input #(
    parameter logic [8:0] KEY_RIGHT          = 9'h174,
    parameter logic [8:0] KEY_LEFT           = 9'h16B,
    parameter logic [8:0] KEY_UP             = 9'h175,
    parameter logic [8:0] KEY_DOWN           = 9'h172,
    parameter logic [8:0] KEY_JUMP           = 9'h029,
    parameter int         STUCK_FRAMES       = 120,
    parameter int         JUMP_REPEAT_FRAMES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    output logic       ask_move_right,
    output logic       ask_move_left,
    output logic       ask_move_up,
    output logic       ask_move_down,
    output logic       ask_move_jump
);

    localparam int WDW = $clog2(STUCK_FRAMES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(STUCK_FRAMES - 1);

    if (STUCK_FRAMES < 1 || JUMP_REPEAT_FRAMES < 2) begin : g_bad_param
        $error("kong_key_input: STUCK_FRAMES >= 1 and JUMP_REPEAT_FRAMES >= 2 required");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_WINDOW = 2'd2
    } jump_state_t;

    // Bit order: 0=right 1=left 2=up 3=down 4=jump
    logic [4:0]     r_held;
    logic [WDW-1:0] r_wd;
    jump_state_t    r_state;
    logic           r_jump;

    logic [4:0] w_match;
    logic [4:0] w_held_ev;
    logic [4:0] w_held_nxt;
    logic       w_event;
    logic       w_timeout;
    logic       w_jump_arm;

`ifdef KONG_JUMP_AUTOREPEAT_EN
    localparam int RPW = $clog2(JUMP_REPEAT_FRAMES + 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(JUMP_REPEAT_FRAMES - 1);
    logic [RPW-1:0] r_rep;
`endif

    always_comb begin
        w_match = {keyCode == KEY_JUMP, keyCode == KEY_DOWN, keyCode == KEY_UP,
                   keyCode == KEY_LEFT, keyCode == KEY_RIGHT};
        w_event = make | brakee;
        w_held_ev = r_held;
        if (brakee) begin
            w_held_ev = r_held & ~w_match;
        end else if (make) begin
            w_held_ev = r_held | w_match;
        end
        w_timeout = !w_event && startOfFrame && (|r_held) && (r_wd == WD_LAST);
        w_held_nxt = w_timeout ? 5'b0 : w_held_ev;
        // Typematic repeats of an already held jump key never re-arm
        w_jump_arm = make && !brakee && w_match[4] && !r_held[4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_held  <= '0;
            r_wd    <= '0;
            r_state <= S_IDLE;
            r_jump  <= 1'b0;
`ifdef KONG_JUMP_AUTOREPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_held <= w_held_nxt;

            if (w_event || w_timeout || r_held == 5'b0) begin
                r_wd <= '0;
            end else if (startOfFrame) begin
                r_wd <= r_wd + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_jump_arm) begin
                        r_state <= S_ARMED;
                        r_jump  <= 1'b1;
                    end
`ifdef KONG_JUMP_AUTOREPEAT_EN
                    else if (startOfFrame && w_held_nxt[4]) begin
                        if (r_rep == RP_LAST) begin
                            r_state <= S_ARMED;
                            r_jump  <= 1'b1;
                            r_rep   <= '0;
                        end else begin
                            r_rep <= r_rep + 1'b1;
                        end
                    end
`endif
                end
                S_ARMED: begin
                    if (startOfFrame) begin
                        r_state <= S_WINDOW;
                    end
                end
                S_WINDOW: begin
                    if (startOfFrame) begin
                        r_state <= S_IDLE;
                        r_jump  <= 1'b0;
`ifdef KONG_JUMP_AUTOREPEAT_EN
                        r_rep   <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_jump  <= 1'b0;
                end
            endcase

`ifdef KONG_JUMP_AUTOREPEAT_EN
            if (!w_held_nxt[4]) begin
                r_rep <= '0;
            end
`endif
        end
    end

    assign ask_move_right = r_held[0];
    assign ask_move_left  = r_held[1];
    assign ask_move_up    = r_held[2];
    assign ask_move_down  = r_held[3];
    assign ask_move_jump  = r_jump;

endmodule

// File: doc/kong_key_input.md
# kong_key_input

Keyboard front-end for the Kong player. Turns raw PS/2 scan events (`keyCode`, `make`, `brakee`) into the per-direction request levels `ask_move_right/left/up/down` and a one-shot `ask_move_jump` for `kong_logic`. `kong_logic` ORs these requests over each frame and samples them at `startOfFrame`. The block also:
- tracks which keys are held,
- turns a jump press into a request that spans exactly one complete frame,
- clears stuck keys when brake codes are lost.

## Interface
Parameters:
- `KEY_RIGHT`, 9'h174: scan code for move right (extended right arrow).
- `KEY_LEFT`, 9'h16B: scan code for move left.
- `KEY_UP`, 9'h175: scan code for move up.
- `KEY_DOWN`, 9'h172: scan code for move down.
- `KEY_JUMP`, 9'h029: scan code for jump (space).
- `STUCK_FRAMES`, 120: frames without any make/brake event before all held keys are released; minimum 1.
- `JUMP_REPEAT_FRAMES`, 20: auto-repeat period in frames; used only with `KONG_JUMP_AUTOREPEAT_EN`; minimum 2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle frame strobe, the same one `kong_logic` uses.
- `keyCode` in 9: scan code; bit 8 is the E0-extended flag. Valid only while `make` or `brakee` is high.
- `make` in 1: one-cycle key-press pulse. Repeats while the key is held (PS/2 typematic).
- `brakee` in 1: one-cycle key-release pulse.
- `ask_move_right` out 1: right key held.
- `ask_move_left` out 1: left key held.
- `ask_move_up` out 1: up key held.
- `ask_move_down` out 1: down key held.
- `ask_move_jump` out 1: jump request window.

## Operation
- Held-key register: 5 bits, one per key (R, L, U, D, J).
  - `make` with a matching `keyCode` sets that key's bit.
  - `brakee` with a matching `keyCode` clears it.
  - Events with unmatched codes are ignored. They still count as activity for the watchdog.
- `make` and `brakee` asserted in the same cycle: `brakee` wins, so the bit is cleared.
- `ask_move_right/left/up/down` are registered copies of the R/L/U/D held bits. Left+right or up+down may be active together; `kong_logic` arbitrates.
- Jump FSM states:
  - IDLE: `ask_move_jump` = 0. On a jump `make` while J was clear → ARMED. A jump `make` while J is already set (typematic repeat) is ignored.
  - ARMED: `ask_move_jump` = 1. On the first `startOfFrame` → WINDOW.
  - WINDOW: `ask_move_jump` = 1. On the next `startOfFrame` → IDLE.
  - The request therefore covers one complete frame interval: `kong_logic` sees it exactly once.
- A jump `brakee` during ARMED or WINDOW does not shorten the window.
- Stuck-key watchdog:
  - The frame counter clears on any `make` or `brakee`.
  - Otherwise it increments on `startOfFrame` while any held bit is set; it stays at 0 while no key is held.
  - When it reaches `STUCK_FRAMES`, all held bits clear and the counter clears. The jump FSM is not affected.
  - Counter width is `$clog2(STUCK_FRAMES+1)`. It saturates and never wraps.

## Timing
- Reset values: all held bits 0, all `ask_move_*` 0, jump FSM IDLE, counters 0.
- Direction latency: an event at cycle t changes the matching `ask_move_*` at cycle t+1.
- Jump latency: a press at cycle t raises `ask_move_jump` at t+1. It drops one cycle after the second `startOfFrame` seen after cycle t.
- Jump `make` and `startOfFrame` in the same cycle: that `startOfFrame` does not count; the FSM enters ARMED.
- `reset` asserted mid-window: `ask_move_jump` is 0 on the next cycle. A key still physically held is not re-reported until its next typematic `make`.
- `startOfFrame` in the same cycle as an event: the watchdog counter clears; it does not increment.

## Configuration
- `KONG_JUMP_AUTOREPEAT_EN` defined:
  - While J stays held, the FSM re-enters ARMED every `JUMP_REPEAT_FRAMES` frames, counted from the `startOfFrame` that ended the previous WINDOW.
  - The repeat counter clears when J is released.
- `KONG_JUMP_AUTOREPEAT_EN` undefined: exactly one jump per press. A new jump requires a jump `brakee` followed by a new jump `make`.

## Test plan
- `make`, 9'h174 at cycle 10 → `ask_move_right` = 1 from cycle 11. `brakee`, 9'h174 at cycle 50 → 0 from cycle 51. All other outputs stay 0.
- Jump `make` at cycle 5, `startOfFrame` at cycles 100 and 200 → `ask_move_jump` high for cycles 6–200, low from 201. Typematic jump `make`s at cycles 150 and 300 cause no further assertion.
- Jump `make` in the same cycle as `startOfFrame` at cycle 100, next strobes at 200 and 300 → `ask_move_jump` high for cycles 101–300.
- `make` 9'h16B with no brake, `STUCK_FRAMES`=3, no further events → `ask_move_left` drops one cycle after the 3rd `startOfFrame`. Add a `make`, 9'h01C (unmatched) before the 3rd strobe → the count restarts.
- `make` and `brakee` for 9'h175 in the same cycle → `ask_move_up` stays 0. `reset` during a jump WINDOW → all outputs 0 next cycle, FSM IDLE.
- With `KONG_JUMP_AUTOREPEAT_EN`, `JUMP_REPEAT_FRAMES`=4, J held → a jump window every 4 frames after each WINDOW ends. Without the macro → a single window only.
